task_dispatch_scheduler: RTL and testbench

//  Front-end scheduler for the server pool. Arbitrates round-robin between NUM_REQ task

---
 rtl/task_dispatch_scheduler.sv | 161 ++++++++++++++++
 tb/tb_task_dispatch_scheduler.sv | 386 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/task_dispatch_scheduler.sv
// Round-robin task arbiter that dispatches each granted task to the least-loaded server.
// Optional statistics counters are built when DISPATCH_STATS_EN is defined.
module task_dispatch_scheduler #(
    parameter int NUM_REQ  = 4,
    parameter int NUM_SRV  = 3,
    parameter int CNT_W    = 4,
    parameter int MAX_LOAD = 7,
    parameter int TRIG_LVL = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_SRV-1:0]       srv_done,
    output logic                     dispatch_valid,
    output logic [1:0]               dispatch_srv,
    output logic [2:0]               dispatch_req,
    output logic [NUM_SRV*CNT_W-1:0] srv_load,
    output logic                     trigger,
    output logic                     overload,
    output logic                     busy,
    output logic [15:0]              stat_dispatched,
    output logic [15:0]              stat_stall_cyc
);

    localparam int REQ_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int SRV_W = $clog2(NUM_SRV);
    localparam logic [CNT_W-1:0] MAX_L    = CNT_W'(MAX_LOAD);
    localparam logic [CNT_W-1:0] TRIG_L   = CNT_W'(TRIG_LVL);
    localparam logic [REQ_W-1:0] LAST_REQ = REQ_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, GRANT, STALL, DISPATCH} state_t;

    state_t           state, state_nxt;
    logic [REQ_W-1:0] rr_ptr, winner, arb_idx;
    logic [SRV_W-1:0] sel_srv, min_idx;
    logic [CNT_W-1:0] min_val;
    logic [CNT_W-1:0] load     [NUM_SRV];
    logic [CNT_W-1:0] load_nxt [NUM_SRV];
    logic             trig_any, trig_all;
    int               cand;

    // Rotating priority search starting at rr_ptr.
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        arb_idx = '0;
        cand    = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (req_valid[cand[REQ_W-1:0]]) arb_idx = cand[REQ_W-1:0];
        end
    end

    // Strict '<' keeps ties on the lowest-index server.
    always_comb begin
        min_val = load[0];
        min_idx = '0;
        for (int s = 1; s < NUM_SRV; s++) begin
            if (load[s] < min_val) begin
                min_val = load[s];
                min_idx = SRV_W'(s);
            end
        end
    end

    // A dispatch and a done on the same server cancel out.
    always_comb begin
        for (int s = 0; s < NUM_SRV; s++) begin
            load_nxt[s] = load[s];
            if (state == DISPATCH && sel_srv == SRV_W'(s)) begin
                if (!srv_done[s] && load[s] < MAX_L) load_nxt[s] = load[s] + 1'b1;
            end else if (srv_done[s] && load[s] != '0) begin
                load_nxt[s] = load[s] - 1'b1;
            end
        end
    end

    always_comb begin
        trig_any = 1'b0;
        trig_all = 1'b1;
        for (int s = 0; s < NUM_SRV; s++) begin
            if (load[s] >= TRIG_L) trig_any = 1'b1;
            else                   trig_all = 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (|req_valid) state_nxt = GRANT;
            GRANT:    state_nxt = (min_val < MAX_L) ? DISPATCH : STALL;
            STALL: begin
                if (!req_valid[winner])   state_nxt = IDLE;
                else if (min_val < MAX_L) state_nxt = DISPATCH;
            end
            DISPATCH: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // NOTE: the small load array is reset explicitly; it is a register file, not a RAM.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_ptr   <= '0;
            winner   <= '0;
            sel_srv  <= '0;
            trigger  <= 1'b0;
            overload <= 1'b0;
            for (int s = 0; s < NUM_SRV; s++) load[s] <= '0;
        end else begin
            if (state == IDLE && |req_valid) winner <= arb_idx;
            if (state == GRANT || state == STALL) sel_srv <= min_idx;
            if (state == DISPATCH) rr_ptr <= (winner == LAST_REQ) ? '0 : winner + 1'b1;
            for (int s = 0; s < NUM_SRV; s++) load[s] <= load_nxt[s];
            trigger  <= trig_any;
            overload <= trig_all;
        end
    end

    always_comb begin
        req_ready      = '0;
        dispatch_valid = 1'b0;
        dispatch_srv   = '0;
        dispatch_req   = '0;
        if (state == DISPATCH) begin
            dispatch_valid    = 1'b1;
            req_ready[winner] = 1'b1;
            dispatch_srv      = 2'(sel_srv);
            dispatch_req      = 3'(winner);
        end
    end

    assign busy = (state != IDLE);

    for (genvar g = 0; g < NUM_SRV; g++) begin : g_pack
        assign srv_load[g*CNT_W +: CNT_W] = load[g];
    end

`ifdef DISPATCH_STATS_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_dispatched <= '0;
            stat_stall_cyc  <= '0;
        end else begin
            if (state == DISPATCH) stat_dispatched <= stat_dispatched + 16'd1;
            if (state == STALL && stat_stall_cyc != 16'hFFFF) stat_stall_cyc <= stat_stall_cyc + 16'd1;
        end
    end
`else
    assign stat_dispatched = '0;
    assign stat_stall_cyc  = '0;
`endif

endmodule

// File: tb/tb_task_dispatch_scheduler.sv
// Directed-vector bench for task_dispatch_scheduler; expected values are hand-computed
// for NUM_REQ=4, NUM_SRV=3, CNT_W=4, MAX_LOAD=7, TRIG_LVL=3.
module tb_task_dispatch_scheduler;

    logic        clk;
    logic        reset;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [2:0]  srv_done;
    logic        dispatch_valid;
    logic [1:0]  dispatch_srv;
    logic [2:0]  dispatch_req;
    logic [11:0] srv_load;
    logic        trigger;
    logic        overload;
    logic        busy;
    logic [15:0] stat_dispatched;
    logic [15:0] stat_stall_cyc;

    int vectors    = 0;
    int miscompares = 0;

`ifdef DISPATCH_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    task_dispatch_scheduler dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .srv_done(srv_done), .dispatch_valid(dispatch_valid), .dispatch_srv(dispatch_srv),
        .dispatch_req(dispatch_req), .srv_load(srv_load), .trigger(trigger),
        .overload(overload), .busy(busy), .stat_dispatched(stat_dispatched),
        .stat_stall_cyc(stat_stall_cyc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset     = 1'b1;
        req_valid = '0;
        srv_done  = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic wait_dispatch(input int max_cyc, output int cyc);
        cyc = 0;
        while (dispatch_valid !== 1'b1 && cyc < max_cyc) begin
            step();
            cyc++;
        end
    endtask

    // Runs n dispatches with pattern pat held; returns inside the last dispatch cycle with req_valid cleared.
    task automatic do_dispatches(input int n, input logic [3:0] pat);
        int cyc;
        req_valid = pat;
        for (int i = 0; i < n; i++) begin
            wait_dispatch(10, cyc);
            vectors++;
            if (dispatch_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL fill_dispatch_%0d: valid=%0b after %0d cycles, expected 1", i, dispatch_valid, cyc);
            end
            if (i < n - 1) step();
            else req_valid = '0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = '0; srv_done = '0;
        #1;
        vectors++;
        if ({busy, dispatch_valid, req_ready, dispatch_srv, dispatch_req, srv_load, trigger, overload} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: busy=%0b dv=%0b rdy=%0h srv=%0d req=%0d load=%0h trig=%0b ovl=%0b, expected all 0",
                     busy, dispatch_valid, req_ready, dispatch_srv, dispatch_req, srv_load, trigger, overload);
        end
        vectors++;
        if ({stat_dispatched, stat_stall_cyc} !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_stats: got %0h/%0h expected 0/0", stat_dispatched, stat_stall_cyc);
        end
        step();
        reset = 1'b0;
    endtask

    task automatic test_single();
        apply_reset();
        req_valid = 4'b0001;
        step();
        vectors++;
        if (busy !== 1'b1 || dispatch_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_grant: busy=%0b dv=%0b expected 1/0", busy, dispatch_valid);
        end
        step();
        vectors++;
        if ({dispatch_valid, dispatch_srv, dispatch_req, req_ready} !== {1'b1, 2'd0, 3'd0, 4'b0001}) begin
            miscompares++;
            $display("FAIL single_dispatch: dv=%0b srv=%0d req=%0d rdy=%b expected 1/0/0/0001",
                     dispatch_valid, dispatch_srv, dispatch_req, req_ready);
        end
        req_valid = '0;
        step();
        vectors++;
        if (srv_load !== 12'h001 || dispatch_valid !== 1'b0 || dispatch_srv !== 2'd0) begin
            miscompares++;
            $display("FAIL single_load: load=%0h dv=%0b srv=%0d expected 001/0/0", srv_load, dispatch_valid, dispatch_srv);
        end
    endtask

    task automatic test_round_robin();
        int cyc;
        int exp_req [4] = '{0, 1, 2, 3};
        int exp_srv [4] = '{0, 1, 2, 0};
        apply_reset();
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            wait_dispatch(10, cyc);
            vectors++;
            if (dispatch_valid !== 1'b1 || cyc != 2) begin
                miscompares++;
                $display("FAIL rr_latency_%0d: dv=%0b after %0d cycles, expected 1 after 2", i, dispatch_valid, cyc);
            end
            vectors++;
            if (dispatch_req !== 3'(exp_req[i]) || dispatch_srv !== 2'(exp_srv[i]) || req_ready !== 4'(1 << exp_req[i])) begin
                miscompares++;
                $display("FAIL rr_order_%0d: req=%0d srv=%0d rdy=%b expected req=%0d srv=%0d",
                         i, dispatch_req, dispatch_srv, req_ready, exp_req[i], exp_srv[i]);
            end
            step();
        end
        vectors++;
        if (srv_load !== 12'h112 || trigger !== 1'b0) begin
            miscompares++;
            $display("FAIL rr_loads: load=%0h trig=%0b expected 112/0", srv_load, trigger);
        end
        req_valid = '0;
    endtask

    task automatic test_stall();
        apply_reset();
        do_dispatches(21, 4'b0001);
        vectors++;
        if (dispatch_srv !== 2'd2) begin
            miscompares++;
            $display("FAIL stall_fill_last: srv=%0d expected 2", dispatch_srv);
        end
        step();
        vectors++;
        if (srv_load !== 12'h777) begin
            miscompares++;
            $display("FAIL stall_full: load=%0h expected 777", srv_load);
        end
        req_valid = 4'b0001;
        step();
        step();
        vectors++;
        if (busy !== 1'b1 || dispatch_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_enter: busy=%0b dv=%0b expected 1/0", busy, dispatch_valid);
        end
        repeat (3) step();
        vectors++;
        if (dispatch_valid !== 1'b0 || req_ready !== 4'b0000) begin
            miscompares++;
            $display("FAIL stall_hold: dv=%0b rdy=%b expected 0/0000", dispatch_valid, req_ready);
        end
        srv_done = 3'b010;
        step();
        srv_done = '0;
        vectors++;
        if (srv_load !== 12'h767 || dispatch_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL stall_done: load=%0h dv=%0b expected 767/0", srv_load, dispatch_valid);
        end
        step();
        vectors++;
        if ({dispatch_valid, dispatch_srv, dispatch_req, req_ready} !== {1'b1, 2'd1, 3'd0, 4'b0001}) begin
            miscompares++;
            $display("FAIL stall_release: dv=%0b srv=%0d req=%0d rdy=%b expected 1/1/0/0001",
                     dispatch_valid, dispatch_srv, dispatch_req, req_ready);
        end
        vectors++;
        if (stat_stall_cyc !== (STATS ? 16'd5 : 16'd0)) begin
            miscompares++;
            $display("FAIL stall_count: got %0d expected %0d", stat_stall_cyc, STATS ? 5 : 0);
        end
        req_valid = '0;
        step();
        vectors++;
        if (srv_load !== 12'h777 || stat_dispatched !== (STATS ? 16'd22 : 16'd0)) begin
            miscompares++;
            $display("FAIL stall_after: load=%0h disp=%0d expected 777/%0d", srv_load, stat_dispatched, STATS ? 22 : 0);
        end
    endtask

    task automatic test_counter_edges();
        int cyc;
        apply_reset();
        do_dispatches(7, 4'b0001);
        step();
        vectors++;
        if (srv_load !== 12'h223) begin
            miscompares++;
            $display("FAIL cnt_setup: load=%0h expected 223", srv_load);
        end
        req_valid = 4'b0001;
        wait_dispatch(10, cyc);
        vectors++;
        if (dispatch_valid !== 1'b1 || dispatch_srv !== 2'd1) begin
            miscompares++;
            $display("FAIL cnt_pick: dv=%0b srv=%0d expected 1/1", dispatch_valid, dispatch_srv);
        end
        srv_done  = 3'b010;
        req_valid = '0;
        step();
        srv_done = '0;
        vectors++;
        if (srv_load !== 12'h223) begin
            miscompares++;
            $display("FAIL cnt_cancel: load=%0h expected 223", srv_load);
        end
        srv_done = 3'b101;
        step();
        srv_done = '0;
        vectors++;
        if (srv_load !== 12'h122) begin
            miscompares++;
            $display("FAIL cnt_multi_done: load=%0h expected 122", srv_load);
        end
        apply_reset();
        srv_done = 3'b100;
        step();
        vectors++;
        if (srv_load !== 12'h000) begin
            miscompares++;
            $display("FAIL cnt_underflow2: load=%0h expected 000", srv_load);
        end
        srv_done = 3'b111;
        step();
        srv_done = '0;
        vectors++;
        if (srv_load !== 12'h000) begin
            miscompares++;
            $display("FAIL cnt_underflow_all: load=%0h expected 000", srv_load);
        end
    endtask

    task automatic test_trigger();
        apply_reset();
        do_dispatches(9, 4'b0001);
        vectors++;
        if (trigger !== 1'b1 || overload !== 1'b0) begin
            miscompares++;
            $display("FAIL trig_partial: trig=%0b ovl=%0b expected 1/0", trigger, overload);
        end
        step();
        vectors++;
        if (srv_load !== 12'h333 || overload !== 1'b0) begin
            miscompares++;
            $display("FAIL ovl_lag: load=%0h ovl=%0b expected 333/0", srv_load, overload);
        end
        step();
        vectors++;
        if (overload !== 1'b1) begin
            miscompares++;
            $display("FAIL ovl_set: ovl=%0b expected 1", overload);
        end
        srv_done = 3'b110;
        step();
        vectors++;
        if (srv_load !== 12'h223 || overload !== 1'b1) begin
            miscompares++;
            $display("FAIL ovl_hold_lag: load=%0h ovl=%0b expected 223/1", srv_load, overload);
        end
        step();
        step();
        srv_done = '0;
        step();
        vectors++;
        if (srv_load !== 12'h003 || trigger !== 1'b1 || overload !== 1'b0) begin
            miscompares++;
            $display("FAIL trig_300: load=%0h trig=%0b ovl=%0b expected 003/1/0", srv_load, trigger, overload);
        end
        srv_done = 3'b001;
        step();
        vectors++;
        if (srv_load !== 12'h002 || trigger !== 1'b1) begin
            miscompares++;
            $display("FAIL trig_lag: load=%0h trig=%0b expected 002/1", srv_load, trigger);
        end
        step();
        srv_done = '0;
        vectors++;
        if (trigger !== 1'b0) begin
            miscompares++;
            $display("FAIL trig_clear: trig=%0b expected 0", trigger);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        apply_reset();
        do_dispatches(21, 4'b0001);
        step();
        req_valid = 4'b0001;
        step();
        step();
        req_valid = '0;
        step();
        vectors++;
        if (busy !== 1'b0 || dispatch_valid !== 1'b0 || srv_load !== 12'h777) begin
            miscompares++;
            $display("FAIL stall_drop: busy=%0b dv=%0b load=%0h expected 0/0/777", busy, dispatch_valid, srv_load);
        end
        req_valid = 4'b0001;
        step();
        step();
        reset = 1'b1;
        #1;
        vectors++;
        if ({busy, dispatch_valid, req_ready, srv_load, trigger, overload} !== '0) begin
            miscompares++;
            $display("FAIL reset_in_stall: busy=%0b dv=%0b rdy=%b load=%0h trig=%0b ovl=%0b expected all 0",
                     busy, dispatch_valid, req_ready, srv_load, trigger, overload);
        end
        step();
        reset = 1'b0;
        wait_dispatch(10, cyc);
        req_valid = 4'b1111;
        step();
        wait_dispatch(10, cyc);
        vectors++;
        if (dispatch_valid !== 1'b1 || dispatch_req !== 3'd1) begin
            miscompares++;
            $display("FAIL pre_reset_dispatch: dv=%0b req=%0d expected 1/1", dispatch_valid, dispatch_req);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if ({busy, dispatch_valid, req_ready, dispatch_req, dispatch_srv, srv_load} !== '0) begin
            miscompares++;
            $display("FAIL reset_in_dispatch: busy=%0b dv=%0b rdy=%b req=%0d srv=%0d load=%0h expected all 0",
                     busy, dispatch_valid, req_ready, dispatch_req, dispatch_srv, srv_load);
        end
        step();
        reset = 1'b0;
        wait_dispatch(10, cyc);
        vectors++;
        if (dispatch_valid !== 1'b1 || dispatch_req !== 3'd0 || dispatch_srv !== 2'd0) begin
            miscompares++;
            $display("FAIL post_reset_grant: dv=%0b req=%0d srv=%0d expected 1/0/0", dispatch_valid, dispatch_req, dispatch_srv);
        end
        req_valid = '0;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_stall();
        test_counter_edges();
        test_trigger();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
